// File: rtl/bcd_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared BCD widths, controller state encoding and digit check.
// Rev    : 1.0
// ============================================================================
package bcd_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_W'(MAX_DIGIT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_mult_seq_if
// Brief  : start/busy/done handshake and operand/product bus of the multiplier.
// Rev    : 1.0
// ============================================================================
interface bcd_mult_seq_if
    import bcd_pkg::*;
#(
    parameter int N = 2
);

    logic                     start;
    logic [N*DIGIT_W-1:0]     a;
    logic [N*DIGIT_W-1:0]     b;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [2*N*DIGIT_W-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, error, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, error, product
    );

endinterface
`default_nettype wire

// File: rtl/bcd_mult_seq_digit_mult.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_mult
// Brief  : Combinational one-digit by one-digit BCD multiply, two-digit result.
// Rev    : 1.0
// ============================================================================
module bcd_digit_mult
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               invalid
);

    logic [6:0] w_bin;

    assign w_bin   = 7'(a) * 7'(b);
    assign invalid = !digit_valid(a) || !digit_valid(b);

    // Product of two valid digits is at most 81, so the tens digit never exceeds 8.
    always_comb begin
        tens = '0;
        for (int k = 1; k <= 8; k++) begin
            if (w_bin >= 7'(10 * k)) begin
                tens = DIGIT_W'(k);
            end
        end
        ones = DIGIT_W'(w_bin - 7'(10) * 7'(tens));
    end

endmodule
`default_nettype wire

// File: rtl/bcd_mult_seq.sv
`default_nettype none
// ============================================================================
// Module : bcd_mult_seq
// Brief  : Sequential N-digit BCD multiplier, one digit pair per cycle.
// Rev    : 1.0
// ============================================================================
module bcd_mult_seq
    import bcd_pkg::*;
#(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    bcd_mult_seq_if.slave  bus
);

    localparam int         c_OP_W  = N * DIGIT_W;
    localparam int         c_ACC_W = 2 * N * DIGIT_W;
    localparam logic [1:0] c_LAST  = 2'(N - 1);

    state_t                r_state;
    logic [c_OP_W-1:0]     r_a;
    logic [c_OP_W-1:0]     r_b;
    logic [1:0]            r_i;
    logic [1:0]            r_j;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_ACC_W-1:0]    r_product;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic [DIGIT_W-1:0]    w_da;
    logic [DIGIT_W-1:0]    w_db;
    logic [DIGIT_W-1:0]    w_pp_tens;
    logic [DIGIT_W-1:0]    w_pp_ones;
    logic                  w_pp_invalid;
    logic                  w_ops_valid;
    logic [2:0]            w_offset;
    logic [c_ACC_W-1:0]    w_pp_ext;
    logic [c_ACC_W-1:0]    w_addend;
    logic [c_ACC_W-1:0]    w_acc_next;
    logic [2*N-1:0]        w_carry;

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.error   = r_error;
    assign bus.product = r_product;

    always_comb begin
        w_da        = '0;
        w_db        = '0;
        w_ops_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (r_i == 2'(k)) w_da = r_a[k*DIGIT_W +: DIGIT_W];
            if (r_j == 2'(k)) w_db = r_b[k*DIGIT_W +: DIGIT_W];
            if (!digit_valid(r_a[k*DIGIT_W +: DIGIT_W]) ||
                !digit_valid(r_b[k*DIGIT_W +: DIGIT_W])) begin
                w_ops_valid = 1'b0;
            end
        end
    end

    bcd_digit_mult u_digit_mult (
        .a       (w_da),
        .b       (w_db),
        .tens    (w_pp_tens),
        .ones    (w_pp_ones),
        .invalid (w_pp_invalid)
    );

    // Place the two-digit partial product at digit position i+j.
    assign w_offset = 3'(r_i) + 3'(r_j);

    always_comb begin
        w_pp_ext                  = '0;
        w_pp_ext[2*DIGIT_W-1:0]   = {w_pp_tens, w_pp_ones};
        w_addend                  = w_pp_ext << (DIGIT_W * int'(w_offset));
    end

    // Ripple decimal adder: a digit sum above 9 is corrected by +6 and carries.
    assign w_carry[0] = 1'b0;

    for (genvar d = 0; d < 2 * N; d++) begin : g_bcd_add
        logic [DIGIT_W:0] w_sum;
        logic             w_adj;

        assign w_sum = {1'b0, r_acc[d*DIGIT_W +: DIGIT_W]}
                     + {1'b0, w_addend[d*DIGIT_W +: DIGIT_W]}
                     + {{DIGIT_W{1'b0}}, w_carry[d]};
        assign w_adj = w_sum[DIGIT_W] || !digit_valid(w_sum[DIGIT_W-1:0]);
        assign w_acc_next[d*DIGIT_W +: DIGIT_W] =
            w_sum[DIGIT_W-1:0] + (w_adj ? DIGIT_W'(6) : DIGIT_W'(0));

        if (d < 2 * N - 1) begin : g_carry
            assign w_carry[d+1] = w_adj;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_acc     <= '0;
                        r_product <= '0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CHECK;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    r_i <= '0;
                    r_j <= '0;
                    if (!w_ops_valid) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_pp_invalid) begin
                        // Captured digits were validated in CHECK; guard kept for robustness.
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_i == c_LAST && r_j == c_LAST) begin
                        r_acc     <= w_acc_next;
                        r_product <= w_acc_next;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_j == c_LAST) begin
                            r_j <= '0;
                            r_i <= r_i + 2'd1;
                        end else begin
                            r_j <= r_j + 2'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
